// File: rtl/hazard_ctrl.sv
// Hazard scheduler beside the ID stage: tracks EX/MEM destination records, raises forwarding
// flags, and sequences load-use and divide stalls.
module hazard_ctrl #(
  parameter int unsigned DivCycles = 32,
  parameter int unsigned CntW      = 6
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       id_valid_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_use_rs_i,
  input  logic       id_use_rt_i,
  input  logic       id_wr_i,
  input  logic [4:0] id_wa_i,
  input  logic       id_is_load_i,
  input  logic       id_is_movz_i,
  input  logic       id_is_div_i,
  output logic       stall_pc_o,
  output logic       stall_ifid_o,
  output logic       bubble_idex_o,
  output logic       id_ex_hazard_mem_o,
  output logic       id_ex_rs_hazard_reg_o,
  output logic       id_ex_rt_hazard_reg_o,
  output logic       id_mem_rs_hazard_mem_o,
  output logic       id_mem_rt_hazard_mem_o,
  output logic       id_mem_rs_hazard_reg_o,
  output logic       id_mem_rt_hazard_reg_o,
  output logic       idex_is_movz_o,
  output logic       exmem_is_movz_o,
  output logic       div_busy_o,
  output logic       div_done_o
);

  typedef struct packed {
    logic       wr;
    logic [4:0] wa;
    logic       load;
    logic       movz;
  } rec_t;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam logic [CntW-1:0] CntInit = CntW'(DivCycles - 1);

  rec_t            ex_q, ex_d, mem_q;
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic match_ex_rs, match_ex_rt, match_mem_rs, match_mem_rt;
  logic stall, id_advance, div_accept;

  // Register $0 is never a real producer, so it never matches.
  function automatic logic src_match(rec_t r, logic vld, logic use_s, logic [4:0] s);
    return vld & use_s & r.wr & (r.wa == s) & (s != 5'd0);
  endfunction

  always_comb begin
    match_ex_rs  = src_match(ex_q, id_valid_i, id_use_rs_i, id_rs_i);
    match_ex_rt  = src_match(ex_q, id_valid_i, id_use_rt_i, id_rt_i);
    match_mem_rs = src_match(mem_q, id_valid_i, id_use_rs_i, id_rs_i);
    match_mem_rt = src_match(mem_q, id_valid_i, id_use_rt_i, id_rt_i);

    id_ex_hazard_mem_o    = ex_q.load & (match_ex_rs | match_ex_rt);
    id_ex_rs_hazard_reg_o = match_ex_rs & ~ex_q.load;
    id_ex_rt_hazard_reg_o = match_ex_rt & ~ex_q.load;

    // The younger producer in EX shadows the older one in MEM.
    id_mem_rs_hazard_mem_o = match_mem_rs & ~match_ex_rs & mem_q.load;
    id_mem_rt_hazard_mem_o = match_mem_rt & ~match_ex_rt & mem_q.load;
    id_mem_rs_hazard_reg_o = match_mem_rs & ~match_ex_rs & ~mem_q.load;
    id_mem_rt_hazard_reg_o = match_mem_rt & ~match_ex_rt & ~mem_q.load;

    idex_is_movz_o  = ex_q.movz;
    exmem_is_movz_o = mem_q.movz;

    div_busy_o    = (state_q == StBusy);
    stall         = id_ex_hazard_mem_o | div_busy_o;
    stall_pc_o    = stall;
    stall_ifid_o  = stall;
    bubble_idex_o = stall;
    id_advance    = ~stall;
    div_accept    = id_valid_i & id_is_div_i & id_advance;
  end

  always_comb begin
    ex_d = '0;
    if (id_advance && id_valid_i) begin
      ex_d.wr   = id_wr_i;
      ex_d.wa   = id_wa_i;
      ex_d.load = id_is_load_i;
      ex_d.movz = id_is_movz_i;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_done_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (div_accept) begin
          state_d = StBusy;
          cnt_d   = CntInit;
        end
      end
      StBusy: begin
        if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        div_done_o = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_q    <= '0;
      mem_q   <= '0;
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= ex_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
